// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared core definitions for the memory-access stage.
// Holds the data/register widths, enable polarities, exception codes,
// memory-op encodings, FSM state type and the misalignment helper.
package mem_stage_pkg;

    localparam int WORD_DATA_W = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int HART_ID_W   = 2;
    localparam int MEM_OP_W    = 4;
    localparam int EXP_CODE_W  = 4;
    localparam int BYTE_EN_W   = WORD_DATA_W / 8;

    localparam logic ENABLE   = 1'b1;
    localparam logic DISABLE  = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam logic [EXP_CODE_W-1:0] EXP_NO_EXP        = 4'd0;
    localparam logic [EXP_CODE_W-1:0] EXP_MISALIGNED_LD = 4'd4;
    localparam logic [EXP_CODE_W-1:0] EXP_MISALIGNED_ST = 4'd6;

    // mem_op[3:2]: access kind
    localparam logic [1:0] MEM_KIND_NONE  = 2'b00;
    localparam logic [1:0] MEM_KIND_LOAD  = 2'b01;
    localparam logic [1:0] MEM_KIND_STORE = 2'b10;
    localparam logic [1:0] MEM_KIND_LOADU = 2'b11;

    // mem_op[1:0]: access size
    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    typedef enum logic [0:0] {
        MEM_ST_IDLE = 1'b0,
        MEM_ST_WAIT = 1'b1
    } mem_state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            MEM_SIZE_B: mis = 1'b0;
            MEM_SIZE_H: mis = addr_lo[0];
            default:    mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-cache request bus.
//   req      master->slave  request valid
//   rw       master->slave  1 = write
//   addr     master->slave  word-aligned address
//   wr_data  master->slave  lane-replicated store data
//   byte_en  master->slave  write byte enables
//   ready    slave->master  one-cycle completion pulse
//   rd_data  slave->master  read data, valid with ready
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                   req;
    logic                   rw;
    logic [WORD_DATA_W-1:0] addr;
    logic [WORD_DATA_W-1:0] wr_data;
    logic [BYTE_EN_W-1:0]   byte_en;
    logic                   ready;
    logic [WORD_DATA_W-1:0] rd_data;

    modport master (
        output req, rw, addr, wr_data, byte_en,
        input  ready, rd_data
    );

    modport slave (
        input  req, rw, addr, wr_data, byte_en,
        output ready, rd_data
    );

endinterface

// File: rtl/mem_align.sv
// mem_align: combinational lane logic for the memory stage.
//   i_mem_op   access kind/size
//   i_addr_lo  byte offset within the word
//   i_wr_data  raw store data
//   i_rd_data  raw cache read word
//   o_ld_data  extracted and sign/zero-extended load data
//   o_st_data  store data replicated across lanes
//   o_byte_en  write byte enables
// Halfword lanes use addr_lo[1] only and words ignore addr_lo, so a
// misaligned access degrades to the aligned one containing it.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [MEM_OP_W-1:0]    i_mem_op,
    input  logic [1:0]             i_addr_lo,
    input  logic [WORD_DATA_W-1:0] i_wr_data,
    input  logic [WORD_DATA_W-1:0] i_rd_data,
    output logic [WORD_DATA_W-1:0] o_ld_data,
    output logic [WORD_DATA_W-1:0] o_st_data,
    output logic [BYTE_EN_W-1:0]   o_byte_en
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sext;

    always_comb begin
        w_sext = (i_mem_op[3:2] != MEM_KIND_LOADU);
        case (i_addr_lo)
            2'b00:   w_byte = i_rd_data[7:0];
            2'b01:   w_byte = i_rd_data[15:8];
            2'b10:   w_byte = i_rd_data[23:16];
            default: w_byte = i_rd_data[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rd_data[31:16] : i_rd_data[15:0];

        case (i_mem_op[1:0])
            MEM_SIZE_B: begin
                o_ld_data = {{24{w_sext & w_byte[7]}}, w_byte};
                o_st_data = {4{i_wr_data[7:0]}};
                o_byte_en = 4'b0001 << i_addr_lo;
            end
            MEM_SIZE_H: begin
                o_ld_data = {{16{w_sext & w_half[15]}}, w_half};
                o_st_data = {2{i_wr_data[15:0]}};
                o_byte_en = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                o_ld_data = i_rd_data;
                o_st_data = i_wr_data;
                o_byte_en = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage. Issues data-cache requests for
// loads/stores from the EX/MEM register, aligns load data, stalls the
// pipeline on a miss and owns the MEM/WB register.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   i_stall, i_flush     hold / bubble the MEM/WB register
//   i_ex_*               EX/MEM register contents (i_ex_out = address or ALU result)
//   dc                   data-cache bus (master side)
//   o_mem_busy           stall request while a miss is outstanding
//   o_mem_*              MEM/WB register
// Build option: MEM_MISALIGN_EXP_EN raises a misaligned-access exception
// instead of silently aligning the access.
//
// state | meaning
// IDLE  | no outstanding access; hits complete here
// WAIT  | miss outstanding, request held until dc.ready
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_stall,
    input  logic                   i_flush,
    input  logic                   i_ex_en,
    input  logic [WORD_DATA_W-1:0] i_ex_pc,
    input  logic [EXP_CODE_W-1:0]  i_ex_exp_code,
    input  logic [MEM_OP_W-1:0]    i_ex_mem_op,
    input  logic [WORD_DATA_W-1:0] i_ex_mem_wr_data,
    input  logic [REG_ADDR_W-1:0]  i_ex_rd_addr,
    input  logic                   i_ex_gpr_we_,
    input  logic [WORD_DATA_W-1:0] i_ex_out,
    input  logic [HART_ID_W-1:0]   i_ex_hart_id,
    mem_stage_if.master            dc,
    output logic                   o_mem_busy,
    output logic                   o_mem_en,
    output logic [WORD_DATA_W-1:0] o_mem_pc,
    output logic [EXP_CODE_W-1:0]  o_mem_exp_code,
    output logic [REG_ADDR_W-1:0]  o_mem_rd_addr,
    output logic                   o_mem_gpr_we_,
    output logic [WORD_DATA_W-1:0] o_mem_out,
    output logic [HART_ID_W-1:0]   o_mem_hart_id
);

    mem_state_e             r_state;
    mem_state_e             w_next_state;
    logic                   r_kill;
    logic                   r_pend_valid;
    logic [WORD_DATA_W-1:0] r_pend_data;
    logic [MEM_OP_W-1:0]    r_req_op;
    logic [WORD_DATA_W-1:0] r_req_addr;
    logic [WORD_DATA_W-1:0] r_req_wr_data;

    logic                   w_valid;
    logic                   w_misaligned;
    logic                   w_access;
    logic                   w_dc_req;
    logic                   w_busy;
    logic                   w_done;
    logic                   w_in_wait;
    logic [MEM_OP_W-1:0]    w_op;
    logic [WORD_DATA_W-1:0] w_addr;
    logic [WORD_DATA_W-1:0] w_wr_data;
    logic [WORD_DATA_W-1:0] w_ld_data;
    logic [WORD_DATA_W-1:0] w_st_data;
    logic [BYTE_EN_W-1:0]   w_byte_en;
    logic                   w_is_store;
    logic                   w_is_load;
    logic [WORD_DATA_W-1:0] w_result;

    assign w_valid = (i_ex_en == ENABLE) && (i_ex_exp_code == EXP_NO_EXP)
                     && (i_ex_mem_op[3:2] != MEM_KIND_NONE);

`ifdef MEM_MISALIGN_EXP_EN
    assign w_misaligned = w_valid && is_misaligned(i_ex_mem_op[1:0], i_ex_out[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    // A result parked during a stall already completed; never re-request it.
    assign w_access = w_valid && !w_misaligned && !r_pend_valid;

    // While waiting, the request comes from the copy taken at issue so a
    // flush that changes the EX/MEM register cannot disturb the cache.
    assign w_in_wait = (r_state == MEM_ST_WAIT);
    assign w_op      = w_in_wait ? r_req_op      : i_ex_mem_op;
    assign w_addr    = w_in_wait ? r_req_addr    : i_ex_out;
    assign w_wr_data = w_in_wait ? r_req_wr_data : i_ex_mem_wr_data;

    assign w_is_store = (w_op[3:2] == MEM_KIND_STORE);
    assign w_is_load  = (w_op[3:2] == MEM_KIND_LOAD) || (w_op[3:2] == MEM_KIND_LOADU);

    mem_align u_mem_align (
        .i_mem_op  (w_op),
        .i_addr_lo (w_addr[1:0]),
        .i_wr_data (w_wr_data),
        .i_rd_data (dc.rd_data),
        .o_ld_data (w_ld_data),
        .o_st_data (w_st_data),
        .o_byte_en (w_byte_en)
    );

    assign dc.req     = w_dc_req;
    assign dc.rw      = w_is_store;
    assign dc.addr    = {w_addr[WORD_DATA_W-1:2], 2'b00};
    assign dc.wr_data = w_st_data;
    assign dc.byte_en = w_is_store ? w_byte_en : '0;
    assign o_mem_busy = w_busy;

    assign w_result = (w_done && w_is_load) ? w_ld_data : i_ex_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MEM_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_dc_req     = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            MEM_ST_IDLE: begin
                if (w_access) begin
                    w_dc_req = 1'b1;
                    if (dc.ready) begin
                        w_done = 1'b1;
                    end else begin
                        w_busy       = 1'b1;
                        w_next_state = MEM_ST_WAIT;
                    end
                end
            end
            MEM_ST_WAIT: begin
                w_dc_req = 1'b1;
                if (dc.ready) begin
                    w_done       = 1'b1;
                    w_next_state = MEM_ST_IDLE;
                end else begin
                    w_busy = 1'b1;
                end
            end
            default: w_next_state = MEM_ST_IDLE;
        endcase
        if (reset) begin
            w_dc_req     = 1'b0;
            w_busy       = 1'b0;
            w_done       = 1'b0;
            w_next_state = MEM_ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_kill        <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_pend_data   <= '0;
            r_req_op      <= '0;
            r_req_addr    <= '0;
            r_req_wr_data <= '0;
        end else begin
            if (r_state == MEM_ST_IDLE) begin
                r_req_op      <= i_ex_mem_op;
                r_req_addr    <= i_ex_out;
                r_req_wr_data <= i_ex_mem_wr_data;
            end

            if (w_done) begin
                r_kill <= 1'b0;
            end else if (i_flush && (w_next_state == MEM_ST_WAIT)) begin
                r_kill <= 1'b1;
            end

            // Any unstalled edge either consumes or flushes the parked result.
            if (!i_stall) begin
                r_pend_valid <= 1'b0;
            end else if (w_done && !r_kill && !i_flush) begin
                r_pend_valid <= 1'b1;
                r_pend_data  <= w_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_mem_en       <= DISABLE;
            o_mem_pc       <= '0;
            o_mem_exp_code <= EXP_NO_EXP;
            o_mem_rd_addr  <= '0;
            o_mem_gpr_we_  <= DISABLE_;
            o_mem_out      <= '0;
            o_mem_hart_id  <= '0;
        end else if (i_stall) begin
            o_mem_en <= o_mem_en;
        end else if (i_flush || w_busy || (w_done && r_kill)) begin
            o_mem_en       <= DISABLE;
            o_mem_pc       <= '0;
            o_mem_exp_code <= EXP_NO_EXP;
            o_mem_rd_addr  <= '0;
            o_mem_gpr_we_  <= DISABLE_;
            o_mem_out      <= '0;
            o_mem_hart_id  <= '0;
        end else begin
            o_mem_en      <= i_ex_en;
            o_mem_pc      <= i_ex_pc;
            o_mem_rd_addr <= i_ex_rd_addr;
            o_mem_hart_id <= i_ex_hart_id;
            o_mem_out     <= r_pend_valid ? r_pend_data : w_result;
            if (w_misaligned) begin
                o_mem_exp_code <= w_is_store ? EXP_MISALIGNED_ST : EXP_MISALIGNED_LD;
                o_mem_gpr_we_  <= DISABLE_;
            end else begin
                o_mem_exp_code <= i_ex_exp_code;
                o_mem_gpr_we_  <= i_ex_gpr_we_;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage. Inputs change 1 ns after
// the rising edge; combinational outputs are checked at the falling
// edge and registered outputs 1 ns after the rising edge.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        ex_en;
    logic [31:0] ex_pc;
    logic [3:0]  ex_exp_code;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_mem_wr_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_gpr_we_;
    logic [31:0] ex_out;
    logic [1:0]  ex_hart_id;
    logic        mem_busy;
    logic        mem_en;
    logic [31:0] mem_pc;
    logic [3:0]  mem_exp_code;
    logic [4:0]  mem_rd_addr;
    logic        mem_gpr_we_;
    logic [31:0] mem_out;
    logic [1:0]  mem_hart_id;

    int errors = 0;
    int checks = 0;

    mem_stage_if dc_if ();

    mem_stage dut (
        .clk              (clk),
        .reset            (reset),
        .i_stall          (stall),
        .i_flush          (flush),
        .i_ex_en          (ex_en),
        .i_ex_pc          (ex_pc),
        .i_ex_exp_code    (ex_exp_code),
        .i_ex_mem_op      (ex_mem_op),
        .i_ex_mem_wr_data (ex_mem_wr_data),
        .i_ex_rd_addr     (ex_rd_addr),
        .i_ex_gpr_we_     (ex_gpr_we_),
        .i_ex_out         (ex_out),
        .i_ex_hart_id     (ex_hart_id),
        .dc               (dc_if),
        .o_mem_busy       (mem_busy),
        .o_mem_en         (mem_en),
        .o_mem_pc         (mem_pc),
        .o_mem_exp_code   (mem_exp_code),
        .o_mem_rd_addr    (mem_rd_addr),
        .o_mem_gpr_we_    (mem_gpr_we_),
        .o_mem_out        (mem_out),
        .o_mem_hart_id    (mem_hart_id)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic en, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] pc);
        ex_en          = en;
        ex_pc          = pc;
        ex_exp_code    = 4'd0;
        ex_mem_op      = op;
        ex_mem_wr_data = wdata;
        ex_rd_addr     = rd;
        ex_gpr_we_     = (op[3:2] == 2'b10) ? 1'b1 : 1'b0;
        ex_out         = addr;
        ex_hart_id     = 2'd1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        dc_if.ready   = 1'b0;
        dc_if.rd_data = 32'h0;
        set_ex(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0, 32'h0);
        step();
        step();
        @(negedge clk);
        checks++; if (dc_if.req !== 1'b0) begin errors++; $display("FAIL reset_dc_req: got %b want 0", dc_if.req); end
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", mem_busy); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
        checks++; if (mem_gpr_we_ !== 1'b1) begin errors++; $display("FAIL reset_gpr_we_: got %b want 1", mem_gpr_we_); end
        checks++; if (mem_out !== 32'h0) begin errors++; $display("FAIL reset_mem_out: got %h want 0", mem_out); end
        checks++; if (mem_pc !== 32'h0) begin errors++; $display("FAIL reset_mem_pc: got %h want 0", mem_pc); end
        checks++; if (mem_exp_code !== 4'd0) begin errors++; $display("FAIL reset_exp_code: got %h want 0", mem_exp_code); end
        step();
        reset = 1'b0;
    endtask

    task automatic test_lw_hit();
        set_ex(1'b1, 4'b0110, 32'h100, 32'h0, 5'd3, 32'h40);
        dc_if.ready   = 1'b1;
        dc_if.rd_data = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (dc_if.req !== 1'b1) begin errors++; $display("FAIL lw_hit_req: got %b want 1", dc_if.req); end
        checks++; if (dc_if.rw !== 1'b0) begin errors++; $display("FAIL lw_hit_rw: got %b want 0", dc_if.rw); end
        checks++; if (dc_if.addr !== 32'h100) begin errors++; $display("FAIL lw_hit_addr: got %h want 100", dc_if.addr); end
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL lw_hit_busy: got %b want 0", mem_busy); end
        step();
        checks++; if (mem_out !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_hit_out: got %h want deadbeef", mem_out); end
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL lw_hit_en: got %b want 1", mem_en); end
        checks++; if (mem_rd_addr !== 5'd3) begin errors++; $display("FAIL lw_hit_rd: got %0d want 3", mem_rd_addr); end
        checks++; if (mem_pc !== 32'h40) begin errors++; $display("FAIL lw_hit_pc: got %h want 40", mem_pc); end
        checks++; if (mem_gpr_we_ !== 1'b0) begin errors++; $display("FAIL lw_hit_we_: got %b want 0", mem_gpr_we_); end
        checks++; if (mem_hart_id !== 2'd1) begin errors++; $display("FAIL lw_hit_hart: got %0d want 1", mem_hart_id); end
    endtask

    task automatic test_back_to_back();
        set_ex(1'b1, 4'b0100, 32'h103, 32'h0, 5'd4, 32'h44);
        dc_if.ready   = 1'b1;
        dc_if.rd_data = 32'h80FFFFFF;
        step();
        checks++; if (mem_out !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext: got %h want ffffff80", mem_out); end
        set_ex(1'b1, 4'b1100, 32'h103, 32'h0, 5'd4, 32'h48);
        step();
        checks++; if (mem_out !== 32'h00000080) begin errors++; $display("FAIL lbu_zext: got %h want 00000080", mem_out); end
        set_ex(1'b1, 4'b1000, 32'h101, 32'h0000005A, 5'd0, 32'h4C);
        @(negedge clk);
        checks++; if (dc_if.byte_en !== 4'b0010) begin errors++; $display("FAIL sb_byte_en: got %b want 0010", dc_if.byte_en); end
        checks++; if (dc_if.wr_data !== 32'h5A5A5A5A) begin errors++; $display("FAIL sb_wr_data: got %h want 5a5a5a5a", dc_if.wr_data); end
        checks++; if (dc_if.rw !== 1'b1) begin errors++; $display("FAIL sb_rw: got %b want 1", dc_if.rw); end
        step();
        checks++; if (mem_out !== 32'h101) begin errors++; $display("FAIL sb_out: got %h want 101", mem_out); end
        checks++; if (mem_gpr_we_ !== 1'b1) begin errors++; $display("FAIL sb_we_: got %b want 1", mem_gpr_we_); end
    endtask

    task automatic test_sh_miss();
        int  busy_cnt = 0;
        int  unstable = 0;
        bit  done = 0;
        set_ex(1'b1, 4'b1001, 32'h102, 32'hABCD1234, 5'd0, 32'h50);
        dc_if.ready = 1'b0;
        for (int c = 0; c < 8 && !done; c++) begin
            dc_if.ready = (c == 3);
            @(negedge clk);
            if (mem_busy === 1'b1) busy_cnt++;
            if (dc_if.req !== 1'b1 || dc_if.rw !== 1'b1 || dc_if.addr !== 32'h100 ||
                dc_if.wr_data !== 32'h12341234 || dc_if.byte_en !== 4'b1100) unstable++;
            if (dc_if.ready) done = 1;
            step();
            if (c == 0) begin
                checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL sh_miss_bubble: got mem_en=%b want 0", mem_en); end
            end
        end
        dc_if.ready = 1'b0;
        checks++; if (!done) begin errors++; $display("FAIL sh_miss_timeout: got no completion want ready by cycle 3"); end
        checks++; if (busy_cnt != 3) begin errors++; $display("FAIL sh_miss_busy_cycles: got %0d want 3", busy_cnt); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL sh_miss_stable: got %0d bad cycles want 0", unstable); end
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL sh_miss_en: got %b want 1", mem_en); end
        checks++; if (mem_out !== 32'h102) begin errors++; $display("FAIL sh_miss_out: got %h want 102", mem_out); end
    endtask

    task automatic test_flush_miss();
        int held_bad = 0;
        set_ex(1'b1, 4'b0110, 32'h200, 32'h0, 5'd5, 32'h60);
        dc_if.ready   = 1'b0;
        dc_if.rd_data = 32'h55;
        for (int c = 0; c < 4; c++) begin
            flush = (c == 1);
            if (c == 1) set_ex(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0, 32'h0);
            dc_if.ready = (c == 3);
            @(negedge clk);
            if (dc_if.req !== 1'b1 || dc_if.addr !== 32'h200 || dc_if.rw !== 1'b0) held_bad++;
            step();
        end
        flush = 1'b0;
        dc_if.ready = 1'b0;
        checks++; if (held_bad != 0) begin errors++; $display("FAIL flush_req_held: got %0d bad cycles want 0", held_bad); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL flush_bubble_en: got %b want 0", mem_en); end
        checks++; if (mem_gpr_we_ !== 1'b1) begin errors++; $display("FAIL flush_bubble_we_: got %b want 1", mem_gpr_we_); end
        checks++; if (mem_out !== 32'h0) begin errors++; $display("FAIL flush_bubble_out: got %h want 0", mem_out); end
        @(negedge clk);
        checks++; if (dc_if.req !== 1'b0) begin errors++; $display("FAIL flush_req_drop: got %b want 0", dc_if.req); end
        step();
        set_ex(1'b1, 4'b0110, 32'h204, 32'h0, 5'd6, 32'h64);
        dc_if.ready   = 1'b1;
        dc_if.rd_data = 32'h12345678;
        step();
        checks++; if (mem_out !== 32'h12345678) begin errors++; $display("FAIL flush_kill_clear: got %h want 12345678", mem_out); end
    endtask

    task automatic test_stall_ready();
        set_ex(1'b1, 4'b0110, 32'h300, 32'h0, 5'd9, 32'h70);
        stall         = 1'b1;
        dc_if.ready   = 1'b1;
        dc_if.rd_data = 32'h11223344;
        @(negedge clk);
        checks++; if (dc_if.req !== 1'b1) begin errors++; $display("FAIL stall_req: got %b want 1", dc_if.req); end
        step();
        checks++; if (mem_out !== 32'h12345678) begin errors++; $display("FAIL stall_hold: got %h want 12345678", mem_out); end
        dc_if.ready   = 1'b0;
        dc_if.rd_data = 32'hFFFFFFFF;
        @(negedge clk);
        checks++; if (dc_if.req !== 1'b0) begin errors++; $display("FAIL stall_no_rereq: got %b want 0", dc_if.req); end
        step();
        stall = 1'b0;
        @(negedge clk);
        checks++; if (dc_if.req !== 1'b0) begin errors++; $display("FAIL stall_release_req: got %b want 0", dc_if.req); end
        step();
        checks++; if (mem_out !== 32'h11223344) begin errors++; $display("FAIL stall_latched: got %h want 11223344", mem_out); end
        checks++; if (mem_rd_addr !== 5'd9) begin errors++; $display("FAIL stall_rd: got %0d want 9", mem_rd_addr); end
        set_ex(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0, 32'h0);
    endtask

    task automatic test_misalign();
        set_ex(1'b1, 4'b0110, 32'h102, 32'h0, 5'd7, 32'h80);
        dc_if.ready   = 1'b1;
        dc_if.rd_data = 32'hCAFEF00D;
        @(negedge clk);
`ifdef MEM_MISALIGN_EXP_EN
        checks++; if (dc_if.req !== 1'b0) begin errors++; $display("FAIL misalign_no_req: got %b want 0", dc_if.req); end
        step();
        checks++; if (mem_exp_code !== EXP_MISALIGNED_LD) begin errors++; $display("FAIL misalign_exp: got %h want %h", mem_exp_code, EXP_MISALIGNED_LD); end
        checks++; if (mem_gpr_we_ !== 1'b1) begin errors++; $display("FAIL misalign_we_: got %b want 1", mem_gpr_we_); end
`else
        checks++; if (dc_if.req !== 1'b1) begin errors++; $display("FAIL misalign_req: got %b want 1", dc_if.req); end
        checks++; if (dc_if.addr !== 32'h100) begin errors++; $display("FAIL misalign_addr: got %h want 100", dc_if.addr); end
        step();
        checks++; if (mem_exp_code !== 4'd0) begin errors++; $display("FAIL misalign_exp: got %h want 0", mem_exp_code); end
        checks++; if (mem_out !== 32'hCAFEF00D) begin errors++; $display("FAIL misalign_out: got %h want cafef00d", mem_out); end
`endif
        dc_if.ready = 1'b0;
        set_ex(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0, 32'h0);
        step();
    endtask

    task automatic test_reset_in_wait();
        set_ex(1'b1, 4'b0110, 32'h400, 32'h0, 5'd8, 32'h90);
        dc_if.ready = 1'b0;
        @(negedge clk);
        checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL rst_wait_enter: got busy=%b want 1", mem_busy); end
        step();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (dc_if.req !== 1'b0) begin errors++; $display("FAIL rst_wait_req_during: got %b want 0", dc_if.req); end
        step();
        reset = 1'b0;
        set_ex(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0, 32'h0);
        @(negedge clk);
        checks++; if (dc_if.req !== 1'b0) begin errors++; $display("FAIL rst_wait_req: got %b want 0", dc_if.req); end
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL rst_wait_busy: got %b want 0", mem_busy); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_wait_en: got %b want 0", mem_en); end
        checks++; if (mem_gpr_we_ !== 1'b1) begin errors++; $display("FAIL rst_wait_we_: got %b want 1", mem_gpr_we_); end
        checks++; if (mem_out !== 32'h0) begin errors++; $display("FAIL rst_wait_out: got %h want 0", mem_out); end
        checks++; if (mem_rd_addr !== 5'd0) begin errors++; $display("FAIL rst_wait_rd: got %0d want 0", mem_rd_addr); end
        checks++; if (mem_pc !== 32'h0) begin errors++; $display("FAIL rst_wait_pc: got %h want 0", mem_pc); end
        step();
    endtask

    initial begin
        test_reset();
        test_lw_hit();
        test_back_to_back();
        test_sh_miss();
        test_flush_miss();
        test_stall_ready();
        test_misalign();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the FMRT Mini Core. It sits directly downstream of the EX/MEM pipeline register. It drives load/store requests to the data cache, aligns and extends load data, and raises a pipeline stall while a cache miss is outstanding. It also owns the MEM/WB pipeline register that feeds write-back.

## Interface
Parameters: none. Widths come from the shared core defines (`WORD_DATA_W`, `REG_ADDR_W`, `HART_ID_W`, `MEM_OP_W`=4).

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- stall  in  1  hold MEM/WB register
- flush  in  1  load bubble into MEM/WB; kill in-flight access
- ex_en, ex_pc, ex_exp_code, ex_mem_op, ex_mem_wr_data, ex_rd_addr, ex_gpr_we_, ex_out, ex_hart_id  in  per defines  EX/MEM register contents; ex_out is the effective address or the ALU result
- dc_req  out  1  cache request
- dc_rw  out  1  1=write
- dc_addr  out  WORD  word-aligned address
- dc_wr_data  out  WORD  store data, lane-shifted
- dc_byte_en  out  4  write byte enables
- dc_ready  in  1  one-cycle completion pulse, may arrive in the request cycle (hit)
- dc_rd_data  in  WORD  valid when dc_ready
- mem_busy  out  1  stall request to the pipeline controller
- mem_en, mem_pc, mem_exp_code, mem_rd_addr, mem_gpr_we_, mem_out, mem_hart_id  out  per defines  MEM/WB register

## Operation
mem_op encoding:
- [3:2]=00: none.
- [3:2]=01: signed load; [1:0] selects size, 00 B / 01 H / 10 W.
- [3:2]=11: unsigned load; [1:0] selects size, 00 BU / 01 HU.
- [3:2]=10: store; [1:0] selects size, 00 B / 01 H / 10 W.

Access is considered only when ex_en=1 and ex_exp_code=`EXP_NO_EXP`.

FSM states:
- IDLE: on an access, assert dc_req combinationally.
  - dc_ready the same cycle: complete, stay in IDLE.
  - Otherwise: go to WAIT and assert mem_busy in that cycle.
- WAIT: hold dc_req and all dc_* outputs stable, mem_busy=1. On dc_ready, return to IDLE; mem_busy drops that cycle.

Load data path:
- Select the byte or halfword by ex_out[1:0] (little-endian).
- Sign-extend or zero-extend per mem_op.

Store data path:
- Replicate data across lanes.
- byte_en: B = 1<<a[1:0]; H = 0011 or 1100 by a[1]; W = 1111.

mem_out source: load data for loads, ex_out otherwise. All other mem_* fields pass through from ex_*.

Flush while in WAIT:
- Set the kill flag.
- The request stays held until dc_ready; the cache transaction is never abandoned, so stores still commit.
- On dc_ready the result is discarded, MEM/WB receives a bubble, and kill clears.

## Timing
- Reset: state IDLE, kill=0, dc_req=0, mem_busy=0.
- MEM/WB reset/bubble values: mem_en=`DISABLE`, mem_pc=0, mem_exp_code=`EXP_NO_EXP`, mem_rd_addr=0, mem_gpr_we_=`DISABLE_`, mem_out=0, mem_hart_id=0.
- Hit: 1 cycle. MEM/WB updates at the edge after the request cycle.
- Miss: N cycles until dc_ready. MEM/WB captures on the dc_ready cycle's edge. While mem_busy=1, MEM/WB loads a bubble.
- Priority: reset > stall (hold) > flush (bubble) > normal.
- If stall=1 coincides with dc_ready, the load result is latched internally and written at the first unstalled edge; no re-request is issued.
- Reset in WAIT returns to IDLE immediately. The cache is also reset.

## Configuration
`MEM_MISALIGN_EXP_EN`:
- Defined: a misaligned access (H with a[0]=1, W with a[1:0]≠0) issues no dc_req. It sets mem_exp_code to `EXP_MISALIGNED_LD` or `EXP_MISALIGNED_ST` and forces mem_gpr_we_=`DISABLE_`, with zero latency.
- Undefined: the low address bits are ignored for H/W, the access is forced aligned, and no exception is raised.

## Structure
- MEM_OP encodings, the EXP_MISALIGNED_* codes and the FSM state constants go in the shared core defines header.
- One natural sub-module: mem_align. It is combinational and handles load extraction/extension, store lane shifting and byte enables.

## Test plan
- LW at 0x100 with a hit (dc_ready in the request cycle), rd_data=0xDEADBEEF → mem_out=0xDEADBEEF, mem_busy never high.
- LB at 0x103 with rd_data=0x80FF_FFFF → mem_out=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x102, data 0x1234, with a 3-cycle miss → dc_byte_en=1100, dc_wr_data=0x12341234. mem_busy is high for 3 cycles and the outputs are stable throughout.
- Flush in cycle 2 of a 4-cycle load miss → dc_req held until dc_ready, then a MEM/WB bubble (mem_gpr_we_=1).
- LW at 0x102 with the macro defined → no dc_req, mem_exp_code=`EXP_MISALIGNED_LD`. Without the macro, dc_addr=0x100.
- Assert reset in WAIT → next cycle state IDLE, dc_req=0, all MEM/WB fields at their reset values.
